pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath (master) presents stage fields; the controller (slave) returns pipeline controls.
interface pipeline_hazard_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_valid;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic        ex_memread;
   logic        ex_mem_access;
   logic        ex_branch_taken;
   logic        wb_regwrite;
   logic [4:0]  wb_wr_regnum;
   logic [4:0]  ex_memread_dst;
   logic        dmem_ack;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_en;
   logic        idex_flush;
   logic        fwd_a;
   logic        fwd_b;
   logic        dmem_req;
   logic [15:0] stall_count;
   logic [1:0]  state;
   logic        mem_timeout;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt,
      output ex_valid, ex_rs, ex_rt, ex_memread, ex_mem_access, ex_branch_taken,
      output wb_regwrite, wb_wr_regnum, ex_memread_dst, dmem_ack,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
      input  fwd_a, fwd_b, dmem_req, stall_count, state, mem_timeout
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt,
      input  ex_valid, ex_rs, ex_rt, ex_memread, ex_mem_access, ex_branch_taken,
      input  wb_regwrite, wb_wr_regnum, ex_memread_dst, dmem_ack,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
      output fwd_a, fwd_b, dmem_req, stall_count, state, mem_timeout
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait handling with timeout-to-halt, WB forwarding and a stall counter.
module pipeline_hazard_ctrl #(
   parameter int INIT_CYCLES = 2,
   parameter int MEM_TIMEOUT = 255
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      HALT     = 2'd3
   } state_t;

   localparam logic [3:0] INIT_LAST  = 4'(INIT_CYCLES - 1);
   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

   state_t      cur_state;
   logic [3:0]  init_cnt;
   logic [7:0]  wait_cnt;
   logic [15:0] stall_count;
   logic        mem_timeout;

   logic hazard;
   logic mem_busy;
   logic mem_stall;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, dmem_req;

   assign hazard = hz.id_valid & hz.ex_valid & hz.ex_memread & (hz.ex_memread_dst != 5'd0) &
                   ((hz.ex_memread_dst == hz.id_rs) |
                    (hz.id_uses_rt & (hz.ex_memread_dst == hz.id_rt)));

   assign mem_busy  = hz.ex_valid & hz.ex_mem_access & ~hz.dmem_ack;

   // In RUN a stall starts only on an outstanding access; once in MEM_WAIT only the ack releases it.
   assign mem_stall = ((cur_state == RUN) & mem_busy) | ((cur_state == MEM_WAIT) & ~hz.dmem_ack);

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      dmem_req   = 1'b0;
      case (cur_state)
         INIT: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         RUN, MEM_WAIT: begin
            dmem_req = hz.ex_valid & hz.ex_mem_access;
            if (mem_stall) begin
               pc_en = 1'b0;
            end else if (hz.ex_branch_taken) begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               idex_en    = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (hazard) begin
               idex_en    = 1'b1;
               idex_flush = 1'b1;
            end else begin
               pc_en   = 1'b1;
               ifid_en = 1'b1;
               idex_en = 1'b1;
            end
         end
         default: pc_en = 1'b0;
      endcase
   end

   // State, flush/wait counters, stall statistics and the sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state   <= INIT;
         init_cnt    <= 4'd0;
         wait_cnt    <= 8'd0;
         stall_count <= 16'd0;
         mem_timeout <= 1'b0;
      end else begin
         if (((cur_state == RUN) || (cur_state == MEM_WAIT)) && !pc_en && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         case (cur_state)
            INIT: begin
               if (init_cnt == INIT_LAST) begin
                  cur_state <= RUN;
                  init_cnt  <= 4'd0;
               end else begin
                  init_cnt <= init_cnt + 4'd1;
               end
            end
            RUN: begin
               if (mem_busy) begin
                  cur_state <= MEM_WAIT;
                  wait_cnt  <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (hz.dmem_ack) begin
                  cur_state <= RUN;
                  wait_cnt  <= 8'd0;
               end else if (wait_cnt >= WAIT_LIMIT) begin
                  cur_state   <= HALT;
                  mem_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: mem_timeout <= 1'b1;
         endcase
      end
   end

   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = ifid_en;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_en     = idex_en;
   assign hz.idex_flush  = idex_flush;
   assign hz.dmem_req    = dmem_req;
   assign hz.fwd_a       = hz.wb_regwrite & (hz.wb_wr_regnum != 5'd0) & (hz.wb_wr_regnum == hz.ex_rs);
   assign hz.fwd_b       = hz.wb_regwrite & (hz.wb_wr_regnum != 5'd0) & (hz.wb_wr_regnum == hz.ex_rt);
   assign hz.stall_count = stall_count;
   assign hz.state       = cur_state;
   assign hz.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a behavioural model predicts every cycle's
// outputs, a monitor compares them at the falling edge.
module tb_pipeline_hazard_ctrl;

   localparam int INIT_CYCLES = 2;
   localparam int MEM_TIMEOUT = 4;

   typedef struct packed {
      logic       rst;
      logic       id_valid;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_uses_rt;
      logic       ex_valid;
      logic [4:0] ex_rs;
      logic [4:0] ex_rt;
      logic       ex_memread;
      logic       ex_mem_access;
      logic       ex_branch_taken;
      logic       wb_regwrite;
      logic [4:0] wb_wr_regnum;
      logic [4:0] ex_memread_dst;
      logic       dmem_ack;
   } stim_t;

   typedef struct packed {
      logic        pc_en;
      logic        ifid_en;
      logic        ifid_flush;
      logic        idex_en;
      logic        idex_flush;
      logic        fwd_a;
      logic        fwd_b;
      logic        dmem_req;
      logic [15:0] stall_count;
      logic [1:0]  state;
      logic        mem_timeout;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exp_t  exp_q[$];
   string tag_q[$];

   int m_state = 0;
   int m_init  = 0;
   int m_wait  = 0;
   int m_stall = 0;
   bit m_mto   = 1'b0;

   pipeline_hazard_ctrl_if bus ();

   pipeline_hazard_ctrl #(
      .INIT_CYCLES(INIT_CYCLES),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .hz   (bus)
   );

   always #5 clk = ~clk;

   function automatic stim_t idleStim();
      stim_t s;
      s = '0;
      s.rst = 1'b1;
      return s;
   endfunction

   function automatic stim_t randStim();
      stim_t s;
      s = idleStim();
      s.id_valid        = ($urandom_range(0, 3) != 0);
      s.id_rs           = 5'($urandom_range(0, 3));
      s.id_rt           = 5'($urandom_range(0, 3));
      s.id_uses_rt      = 1'($urandom_range(0, 1));
      s.ex_valid        = ($urandom_range(0, 3) != 0);
      s.ex_rs           = 5'($urandom_range(0, 3));
      s.ex_rt           = 5'($urandom_range(0, 3));
      s.ex_memread      = 1'($urandom_range(0, 1));
      s.ex_mem_access   = ($urandom_range(0, 9) < 3);
      s.ex_branch_taken = ($urandom_range(0, 9) == 0);
      s.wb_regwrite     = 1'($urandom_range(0, 1));
      s.wb_wr_regnum    = 5'($urandom_range(0, 3));
      s.ex_memread_dst  = 5'($urandom_range(0, 3));
      s.dmem_ack        = ($urandom_range(0, 9) < 6);
      return s;
   endfunction

   // Drives one cycle of inputs, predicts that cycle's outputs, then advances the model.
   task automatic applyStimulus(input stim_t s, input string tag);
      exp_t e;
      bit   hz, busy, stalled;
      @(posedge clk);
      #1;
      reset                  = s.rst;
      bus.id_valid           = s.id_valid;
      bus.id_rs              = s.id_rs;
      bus.id_rt              = s.id_rt;
      bus.id_uses_rt         = s.id_uses_rt;
      bus.ex_valid           = s.ex_valid;
      bus.ex_rs              = s.ex_rs;
      bus.ex_rt              = s.ex_rt;
      bus.ex_memread         = s.ex_memread;
      bus.ex_mem_access      = s.ex_mem_access;
      bus.ex_branch_taken    = s.ex_branch_taken;
      bus.wb_regwrite        = s.wb_regwrite;
      bus.wb_wr_regnum       = s.wb_wr_regnum;
      bus.ex_memread_dst     = s.ex_memread_dst;
      bus.dmem_ack           = s.dmem_ack;

      if (!s.rst) begin
         m_state = 0;
         m_init  = 0;
         m_wait  = 0;
         m_stall = 0;
         m_mto   = 1'b0;
      end

      hz = s.id_valid && s.ex_valid && s.ex_memread && (s.ex_memread_dst != 0) &&
           ((s.ex_memread_dst == s.id_rs) || (s.id_uses_rt && (s.ex_memread_dst == s.id_rt)));
      busy = s.ex_valid && s.ex_mem_access && !s.dmem_ack;

      e = '0;
      e.fwd_a = s.wb_regwrite && (s.wb_wr_regnum != 0) && (s.wb_wr_regnum == s.ex_rs);
      e.fwd_b = s.wb_regwrite && (s.wb_wr_regnum != 0) && (s.wb_wr_regnum == s.ex_rt);
      e.stall_count = 16'(m_stall);
      e.state       = 2'(m_state);
      e.mem_timeout = m_mto;
      if (m_state == 0) begin
         e.ifid_flush = 1'b1;
         e.idex_flush = 1'b1;
      end else if (m_state == 1 || m_state == 2) begin
         e.dmem_req = s.ex_valid && s.ex_mem_access;
         stalled = (m_state == 1) ? busy : !s.dmem_ack;
         if (stalled) begin
            e.pc_en = 1'b0;
         end else if (s.ex_branch_taken) begin
            {e.pc_en, e.ifid_en, e.idex_en, e.ifid_flush, e.idex_flush} = 5'b11111;
         end else if (hz) begin
            {e.idex_en, e.idex_flush} = 2'b11;
         end else begin
            {e.pc_en, e.ifid_en, e.idex_en} = 3'b111;
         end
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);

      if (s.rst) begin
         if ((m_state == 1 || m_state == 2) && !e.pc_en && m_stall < 65535)
            m_stall = m_stall + 1;
         if (m_state == 0) begin
            m_init = m_init + 1;
            if (m_init == INIT_CYCLES) m_state = 1;
         end else if (m_state == 1) begin
            if (busy) begin
               m_state = 2;
               m_wait  = 1;
            end
         end else if (m_state == 2) begin
            if (s.dmem_ack) begin
               m_state = 1;
            end else if (m_wait == MEM_TIMEOUT) begin
               m_state = 3;
               m_mto   = 1'b1;
            end else begin
               m_wait = m_wait + 1;
            end
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops one prediction per cycle and compares the whole output bundle.
   initial begin
      exp_t  e, a;
      string t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                 bus.fwd_a, bus.fwd_b, bus.dmem_req, bus.stall_count, bus.state, bus.mem_timeout};
            checks++;
            if (a !== e) begin
               errors++;
               $display("[TB] FAIL %s: got pc/ifid/ifl/idex/idfl/fa/fb/req=%b cnt=%h st=%0d to=%b expected %b cnt=%h st=%0d to=%b",
                        t, a[26:19], a.stall_count, a.state, a.mem_timeout,
                        e[26:19], e.stall_count, e.state, e.mem_timeout);
            end
         end
      end
   end

   initial begin
      stim_t s;
      stim_t ld;

      ld = idleStim();
      ld.id_valid = 1'b1;  ld.id_rs = 5'd5;  ld.id_rt = 5'd7;
      ld.ex_valid = 1'b1;  ld.ex_memread = 1'b1;  ld.ex_memread_dst = 5'd5;
      ld.ex_mem_access = 1'b1;  ld.dmem_ack = 1'b1;

      s = idleStim();
      s.rst = 1'b0;
      applyStimulus(s, "reset");
      applyStimulus(s, "reset");
      for (int i = 0; i < 4; i++) applyStimulus(idleStim(), "init_release");

      applyStimulus(ld, "load_use");
      applyStimulus(idleStim(), "after_load_use");
      @(negedge clk);
      checkOutput("load_use_stall_count", bus.stall_count, 16'd1);
      s = ld;
      s.ex_memread_dst = 5'd0;
      s.id_rs = 5'd0;
      applyStimulus(s, "load_dst_zero");
      applyStimulus(idleStim(), "after_dst_zero");

      s = idleStim();
      s.ex_valid = 1'b1;
      s.ex_mem_access = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(s, "mem_wait");
      s.dmem_ack = 1'b1;
      applyStimulus(s, "mem_ack");
      applyStimulus(idleStim(), "after_mem");
      @(negedge clk);
      checkOutput("mem_wait_stall_count", bus.stall_count, 16'd4);
      checkOutput("mem_wait_back_to_run", 16'(bus.state), 16'd1);

      s = ld;
      s.ex_branch_taken = 1'b1;
      s.wb_regwrite = 1'b1;
      s.wb_wr_regnum = 5'd0;
      s.ex_rs = 5'd0;
      applyStimulus(s, "branch_hazard_fwd0");
      applyStimulus(idleStim(), "after_branch");
      @(negedge clk);
      checkOutput("branch_stall_unchanged", bus.stall_count, 16'd4);

      s = idleStim();
      s.ex_valid = 1'b1;
      s.ex_mem_access = 1'b1;
      for (int i = 0; i < MEM_TIMEOUT + 3; i++) applyStimulus(s, "timeout");
      @(negedge clk);
      checkOutput("timeout_state_halt", 16'(bus.state), 16'd3);
      checkOutput("timeout_flag", 16'(bus.mem_timeout), 16'd1);
      checkOutput("halt_dmem_req", 16'(bus.dmem_req), 16'd0);
      s.rst = 1'b0;
      applyStimulus(s, "halt_reset");
      @(negedge clk);
      checkOutput("reset_clears_timeout", 16'(bus.mem_timeout), 16'd0);
      checkOutput("reset_to_init", 16'(bus.state), 16'd0);
      for (int i = 0; i < 3; i++) applyStimulus(idleStim(), "restart");

      s = ld;
      s.ex_mem_access = 1'b0;
      for (int i = 0; i < 65538; i++) applyStimulus(s, "saturate");
      @(negedge clk);
      checkOutput("stall_count_saturated", bus.stall_count, 16'hFFFF);

      s = idleStim();
      s.rst = 1'b0;
      applyStimulus(s, "pre_random_reset");
      for (int n = 0; n < 3000; n++) begin
         s = randStim();
         if (m_state == 3 || $urandom_range(0, 99) == 0) s.rst = 1'b0;
         applyStimulus(s, "random");
      end

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
